// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC operation codes, fetch state encoding and
// default bus widths used by the fetch stage and the control FSM.
package cpu_pkg;

    localparam int DEF_INST_W = 18;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [2:0] {
        PC_NOP  = 3'd0,
        PC_LOAD = 3'd1,
        PC_CALL = 3'd2,
        PC_RET  = 3'd3,
        PC_INT  = 3'd4,
        PC_RETI = 3'd5
    } pc_op_e;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUS  = 2'd1,
        FETCH_ACK  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory bus: the fetch unit is the master, memory the slave.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 18
) ();
    logic              cyc;
    logic              stb;
    logic [ADDR_W-1:0] adr;
    logic [INST_W-1:0] dat;
    logic              ack;

    modport master (output cyc, output stb, output adr, input dat, input ack);
    modport slave  (input cyc, input stb, input adr, output dat, output ack);
endinterface

// File: rtl/inst_fetch_unit_ret_stack.sv
// Circular return-address LIFO. A push when full overwrites the oldest
// entry; a pop when empty leaves the pointer alone and reads as zero.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             ovf,
    output logic             unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_prev;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    assign sp_prev = sp - PW'(1);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top     = empty ? '0 : mem[sp_prev];

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[sp] <= push_data;
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            sp <= sp + PW'(1);
            if (full) ovf   <= 1'b1;
            else      count <= count + CW'(1);
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                sp    <= sp_prev;
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, return stack and saved interrupt PC,
// runs the instruction bus handshake and hands a registered IR to control.
//
// state      | meaning
// FETCH_IDLE | waiting; applies PC ops, starts a fetch on fetch_req_i
// FETCH_BUS  | cyc/stb asserted at PC, waiting for memory ack
// FETCH_ACK  | IR just loaded, ir_ack_o pulses for this one cycle
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int INST_W       = DEF_INST_W,
    parameter int RESET_VECTOR = 0,
    parameter int INT_VECTOR   = 1,
    parameter int STACK_DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_req_i,
    input  logic [2:0]        pc_op_i,
    input  logic [ADDR_W-1:0] pc_target_i,
    inst_fetch_unit_if.master bus,
    output logic [INST_W-1:0] ir_o,
    output logic              ir_ack_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              stack_ovf_o,
    output logic              stack_unf_o
);
    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] int_pc;
    logic [INST_W-1:0] ir;
    logic [ADDR_W-1:0] stack_top;
    logic              op_active;
    logic              bus_active;
    logic              ack_pulse;
    logic              in_idle;
    logic              push;
    logic              pop;

    assign in_idle   = (state == FETCH_IDLE);
    assign op_active = pc_op_i inside {PC_LOAD, PC_CALL, PC_RET, PC_INT, PC_RETI};
    assign push      = in_idle && (pc_op_i == PC_CALL);
    assign pop       = in_idle && (pc_op_i == PC_RET);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk       (clk_i),
        .rst_b     (rst_i),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top       (stack_top),
        .ovf       (stack_ovf_o),
        .unf       (stack_unf_o)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= FETCH_IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded outputs; a PC op in IDLE defers the fetch.
    always_comb begin
        state_nxt  = state;
        bus_active = 1'b0;
        ack_pulse  = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (!op_active && fetch_req_i) state_nxt = FETCH_BUS;
            end
            FETCH_BUS: begin
                bus_active = 1'b1;
                if (bus.ack) state_nxt = FETCH_ACK;
            end
            FETCH_ACK: begin
                ack_pulse = 1'b1;
                state_nxt = FETCH_IDLE;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    // PC, saved interrupt PC and IR; PC ops only act in IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc     <= ADDR_W'(RESET_VECTOR);
            int_pc <= '0;
            ir     <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    case (pc_op_i)
                        PC_LOAD: pc <= pc_target_i;
                        PC_CALL: pc <= pc_target_i;
                        PC_RET:  pc <= stack_top;
                        PC_INT: begin
                            int_pc <= pc;
                            pc     <= ADDR_W'(INT_VECTOR);
                        end
                        PC_RETI: pc <= int_pc;
                        default: ;
                    endcase
                end
                FETCH_BUS: begin
                    if (bus.ack) begin
                        ir <= bus.dat;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cyc  = bus_active;
    assign bus.stb  = bus_active;
    assign bus.adr  = pc;
    assign ir_o     = ir;
    assign ir_ack_o = ack_pulse;
    assign pc_o     = pc;
    assign busy_o   = !in_idle;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for the instruction fetch stage: PC-op vector table, a scoreboard
// of expected IR words checked on every ir_ack_o pulse, and hand-written
// sequences for wait states, overflow, wrap and reset during a bus cycle.
module tb_inst_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        fetch_req_i = 1'b0;
    logic [2:0]  pc_op_i = 3'd0;
    logic [11:0] pc_target_i = '0;
    logic [17:0] ir_o;
    logic        ir_ack_o;
    logic [11:0] pc_o;
    logic        busy_o;
    logic        stack_ovf_o;
    logic        stack_unf_o;

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    inst_fetch_unit_if #(.ADDR_W(12), .INST_W(18)) bus ();

    inst_fetch_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_req_i (fetch_req_i),
        .pc_op_i     (pc_op_i),
        .pc_target_i (pc_target_i),
        .bus         (bus),
        .ir_o        (ir_o),
        .ir_ack_o    (ir_ack_o),
        .pc_o        (pc_o),
        .busy_o      (busy_o),
        .stack_ovf_o (stack_ovf_o),
        .stack_unf_o (stack_unf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] tgt;
        logic [11:0] exp_pc;
        logic        exp_unf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [11:0] tgt);
        pc_op_i = op;
        pc_target_i = tgt;
        tick();
        pc_op_i = 3'd0;
        pc_target_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    // Full fetch at 'addr' with 'waits' cycles before the ack.
    task automatic fetch(input logic [17:0] data, input int waits, input logic [11:0] addr);
        logic [11:0] nxt;
        nxt = addr + 12'd1;
        fetch_req_i = 1'b1;
        tick();
        chk("bus_cyc", bus.cyc, 1);
        chk("bus_stb", bus.stb, 1);
        chk("bus_adr", bus.adr, addr);
        chk("busy", busy_o, 1);
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("wait_cyc", bus.cyc, 1);
            chk("wait_stb", bus.stb, 1);
            chk("wait_adr", bus.adr, addr);
            chk("wait_no_ack", ir_ack_o, 0);
        end
        bus.ack = 1'b1;
        bus.dat = data;
        exp_q.push_back(data);
        tick();
        bus.ack = 1'b0;
        bus.dat = '0;
        chk("ack_pulse", ir_ack_o, 1);
        chk("ack_ir", ir_o, data);
        chk("ack_cyc_drop", bus.cyc, 0);
        chk("ack_pc", pc_o, nxt);
        tick();
        chk("post_ack_pulse_end", ir_ack_o, 0);
        chk("post_ack_no_refetch", bus.cyc, 0);
        chk("post_ack_ir_held", ir_o, data);
        fetch_req_i = 1'b0;
    endtask

    // Scoreboard: every ir_ack_o pulse must match the oldest expected word.
    always @(negedge clk_i) begin
        if (ir_ack_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack actual_ir=%0h required=no_pulse", ir_o);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if (ir_o !== e) begin
                    failures++;
                    $display("FAIL sb_ir actual=%0h required=%0h", ir_o, e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{3'd1, 12'h010, 12'h010, 1'b0};
        vecs[1] = '{3'd2, 12'h200, 12'h200, 1'b0};
        vecs[2] = '{3'd3, 12'h000, 12'h010, 1'b0};
        vecs[3] = '{3'd3, 12'h000, 12'h000, 1'b1};
        vecs[4] = '{3'd1, 12'h0FF, 12'h0FF, 1'b1};
        vecs[5] = '{3'd4, 12'h000, 12'h001, 1'b1};
        vecs[6] = '{3'd5, 12'h000, 12'h0FF, 1'b1};
        vecs[7] = '{3'd6, 12'h777, 12'h0FF, 1'b1};
        vecs[8] = '{3'd7, 12'h777, 12'h0FF, 1'b1};
        vecs[9] = '{3'd1, 12'h123, 12'h123, 1'b1};

        bus.ack = 1'b0;
        bus.dat = '0;

        do_reset();
        chk("rst_cyc", bus.cyc, 0);
        chk("rst_stb", bus.stb, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_ir", ir_o, 0);
        chk("rst_ir_ack", ir_ack_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", stack_ovf_o, 0);
        chk("rst_unf", stack_unf_o, 0);

        fetch(18'h2A5A5, 0, 12'h000);
        fetch(18'h12345, 4, 12'h001);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].tgt);
            chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
            chk($sformatf("vec%0d_unf", i), stack_unf_o, vecs[i].exp_unf);
            chk($sformatf("vec%0d_ovf", i), stack_ovf_o, 0);
            chk($sformatf("vec%0d_idle", i), bus.cyc, 0);
        end

        // Nine nested calls overflow an 8-deep stack and drop the oldest.
        do_reset();
        do_op(3'd1, 12'h010);
        for (int i = 0; i < 9; i++) begin
            do_op(3'd2, 12'h100 + 12'(i));
            chk($sformatf("call%0d_ovf", i), stack_ovf_o, (i == 8));
        end
        chk("nested_pc", pc_o, 12'h108);
        do_op(3'd3, 12'h000);
        chk("ret_after_ovf", pc_o, 12'h107);
        for (int i = 0; i < 7; i++) do_op(3'd3, 12'h000);
        chk("ret_oldest_kept", pc_o, 12'h100);
        chk("ret_no_unf", stack_unf_o, 0);
        do_op(3'd3, 12'h000);
        chk("ret_empty_pc", pc_o, 12'h000);
        chk("ret_empty_unf", stack_unf_o, 1);

        // LOAD together with fetch_req: load wins, fetch starts at new PC.
        do_reset();
        fetch_req_i = 1'b1;
        do_op(3'd1, 12'h300);
        chk("sim_load_pc", pc_o, 12'h300);
        chk("sim_load_idle", bus.cyc, 0);
        tick();
        chk("sim_first_adr", bus.adr, 12'h300);
        chk("sim_cyc", bus.cyc, 1);
        do_op(3'd1, 12'h055);
        chk("bus_load_ignored", pc_o, 12'h300);
        chk("bus_load_adr", bus.adr, 12'h300);
        bus.ack = 1'b1;
        bus.dat = 18'h0ABCD;
        exp_q.push_back(18'h0ABCD);
        tick();
        bus.ack = 1'b0;
        chk("sim_ir", ir_o, 18'h0ABCD);
        chk("sim_pc", pc_o, 12'h301);
        tick();
        fetch_req_i = 1'b0;

        // PC wrap at the top of the address space.
        do_op(3'd1, 12'hFFF);
        fetch(18'h3C3C3, 1, 12'hFFF);
        chk("wrap_pc", pc_o, 12'h000);

        // Reset during BUS: cycle dropped, late ack ignored.
        do_reset();
        fetch_req_i = 1'b1;
        tick();
        chk("mid_cyc", bus.cyc, 1);
        rst_i = 1'b0;
        fetch_req_i = 1'b0;
        tick();
        chk("mid_rst_cyc", bus.cyc, 0);
        rst_i = 1'b1;
        bus.ack = 1'b1;
        bus.dat = 18'h3FFFF;
        tick();
        bus.ack = 1'b0;
        bus.dat = '0;
        chk("mid_rst_ir", ir_o, 0);
        chk("mid_rst_no_ack", ir_ack_o, 0);
        chk("mid_rst_pc", pc_o, 0);
        tick();
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage of the 18-bit ALU_CPU, directly upstream of the control FSM. It owns the program counter, an 8-entry subroutine return stack and the saved-interrupt PC. It runs the instruction-memory bus handshake and delivers a registered IR plus a one-cycle acknowledge that the control FSM consumes as `inst_ack_i`. PC redirects (branch, jump, call, return, interrupt entry and exit) arrive from the control path as encoded operations.

## Interface
- `ADDR_W`, 12, instruction address width.
- `INST_W`, 18, instruction width.
- `RESET_VECTOR`, 0, PC value after reset.
- `INT_VECTOR`, 1, PC value loaded on interrupt entry.
- `STACK_DEPTH`, 8, return-stack entries (power of two).

Ports:
- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `fetch_req_i` in 1: control FSM is in fetch state (level).
- `pc_op_i` in 3: PC operation (NOP/LOAD/CALL/RET/INT/RETI).
- `pc_target_i` in ADDR_W: target for LOAD and CALL.
- `inst_cyc_o` out 1: bus cycle active.
- `inst_stb_o` out 1: bus strobe.
- `inst_adr_o` out ADDR_W: fetch address (= PC).
- `inst_dat_i` in INST_W: instruction read data.
- `inst_ack_i` in 1: memory acknowledge.
- `ir_o` out INST_W: registered instruction to the control FSM.
- `ir_ack_o` out 1: one-cycle pulse, IR newly valid; drives the FSM `inst_ack_i`.
- `pc_o` out ADDR_W: current PC.
- `busy_o` out 1: state is not IDLE.
- `stack_ovf_o` out 1: sticky return-stack overflow.
- `stack_unf_o` out 1: sticky return-stack underflow.

## Operation
- **States:** IDLE, BUS, ACK.
- **IDLE:**
  - If `pc_op_i` is not NOP, apply the PC op and stay in IDLE, even if `fetch_req_i` is also high. The fetch starts next cycle with the updated PC.
  - Otherwise, `fetch_req_i` = 1 moves to BUS.
- **BUS:**
  - `inst_cyc_o` = `inst_stb_o` = 1, `inst_adr_o` = PC.
  - On `inst_ack_i`: IR <= `inst_dat_i`, PC <= PC + 1 (wraps 2^ADDR_W - 1 -> 0), go to ACK.
  - Without ack, wait indefinitely.
- **ACK:** `ir_ack_o` = 1 for exactly this cycle, then IDLE unconditionally. `fetch_req_i` is still high here and is ignored.
- **PC ops** are honoured only in IDLE; ignored in BUS and ACK.
  - LOAD: PC <= `pc_target_i`.
  - CALL: push PC (address of the next instruction); PC <= `pc_target_i`.
  - RET: PC <= pop.
  - INT: `int_pc` <= PC; PC <= INT_VECTOR.
  - RETI: PC <= `int_pc`.
  - Codes 6 and 7 are treated as NOP.
- **Return stack:**
  - Push when full: overwrite the oldest entry (pointer wraps), set `stack_ovf_o`.
  - Pop when empty: PC <= 0, pointer unchanged, set `stack_unf_o`.
  - Flags stay set until reset.
- **Reset values:**
  - State IDLE.
  - PC = RESET_VECTOR; IR = 0; `int_pc` = 0.
  - Stack empty.
  - All outputs 0, except `inst_adr_o` and `pc_o` = RESET_VECTOR.

## Timing
- **Fetch latency:** `fetch_req_i` sampled high in IDLE -> `inst_cyc_o`/`inst_stb_o` high the next cycle -> ack in cycle N -> IR and `ir_ack_o` valid in cycle N+1.
  - Zero-wait memory (ack in the first BUS cycle): `ir_ack_o` 2 cycles after the request is sampled.
  - Back-to-back fetches: minimum 3 cycles each.
- `cyc`/`stb`/`adr` are held stable from BUS entry until the ack cycle inclusive. They deassert on the cycle after the ack.
- `ir_o` is held stable until the next ACK; the FSM decodes from it across decode, execute and writeback.
- A PC op takes effect on `pc_o` the cycle after it is sampled.
- **Reset mid-BUS:** `cyc`/`stb` drop on the next edge. An ack that arrives after reset is ignored (state IDLE). IR is not updated.
- `ir_ack_o` is registered, never combinational from `inst_ack_i`.

## Structure
- **Shared package** `cpu_pkg` holds:
  - `pc_op` codes: NOP = 0, LOAD = 1, CALL = 2, RET = 3, INT = 4, RETI = 5;
  - fetch state encoding: IDLE = 0, BUS = 1, ACK = 2;
  - INST_W and ADDR_W defaults, shared with the control FSM.
- **One sub-module:** `ret_stack`, a circular LIFO with push, pop, `top`, `ovf` and `unf`, parameterised by depth and width.

## Test plan
- **Reset then zero-wait fetch:** reset, memory returns 18'h2A5A5 with ack in the first BUS cycle -> `inst_adr_o` = 0, `ir_o` = 18'h2A5A5, one-cycle `ir_ack_o` 2 cycles after the request, `pc_o` = 1.
- **Wait states:** ack delayed 4 cycles -> `cyc`/`stb`/`adr` held constant for 4 cycles, `ir_ack_o` exactly one cycle, no second fetch while `fetch_req_i` is still high in ACK.
- **Call/return:**
  - PC = 0x010, CALL to 0x200 -> PC = 0x200.
  - After 9 nested CALLs, `stack_ovf_o` = 1.
  - RET after a single CALL -> PC = 0x010.
  - RET on an empty stack -> PC = 0, `stack_unf_o` = 1.
- **Interrupt:** PC = 0x0FF, INT -> PC = 0x001; RETI -> PC = 0x0FF.
- **Simultaneous events:** LOAD 0x300 together with `fetch_req_i` in IDLE -> first bus address = 0x300. LOAD issued during BUS -> ignored.
- **Wrap and reset mid-operation:**
  - Fetch at 0xFFF -> PC = 0x000.
  - Assert `rst_i` low in BUS, then ack -> `cyc` = 0 next cycle, IR still 0, no `ir_ack_o`.
